// File: rtl/mux_data_source_pipe.sv
// mux_data_source_pipe: registered write-back source selector.
// Selects one of NUM_SRC packed sources by index and passes the result
// through a 2-entry elastic buffer (main + skid) with valid/ready on both
// sides. Out-of-range selects emit DEFAULT_VAL and set a sticky error.
// Optional feature macro: MUX_DATA_SOURCE_STATS_EN enables the saturating
// output-transfer counter on xfer_cnt (otherwise xfer_cnt is tied to 0).
module mux_data_source_pipe #(
  parameter int                 DATA_W      = 32,
  parameter int                 NUM_SRC     = 10,
  parameter int                 SEL_W       = 4,
  parameter logic [DATA_W-1:0]  DEFAULT_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic                      err,
  output logic [SEL_W-1:0]          err_sel,
  input  logic                      err_clr,
  output logic [15:0]               xfer_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W+1)'(NUM_SRC);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0]  main_sel_q, main_sel_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0]  skid_sel_q, skid_sel_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  err_sel_q, err_sel_d;

  logic              in_fire;
  logic              out_fire;
  logic              sel_ok;
  logic [DATA_W-1:0] entry_data;

  // Handshake qualifiers; in_ready looks only at state and flush.
  assign in_ready  = (state_q != S_TWO) & ~flush;
  assign out_valid = (state_q != S_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign sel_ok    = ({1'b0, sel} < NUM_SRC_W);

  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign err       = err_q;
  assign err_sel   = err_sel_q;

  // Source mux: pick the indexed source, DEFAULT_VAL when out of range.
  always_comb begin
    entry_data = DEFAULT_VAL;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) entry_data = src_in[k*DATA_W +: DATA_W];
    end
  end

  // Buffer next-state: main holds the head entry, skid the overflow one.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_data_d = entry_data;
          main_sel_d  = sel;
          state_d     = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = entry_data;
          main_sel_d  = sel;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end else if (in_fire) begin
          skid_data_d = entry_data;
          skid_sel_d  = sel;
          state_d     = S_TWO;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          state_d     = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush drops every buffered entry; stale data in the regs is harmless.
    if (flush) state_d = S_EMPTY;
  end

  // Sticky error: a new error in the same cycle as a clear wins.
  always_comb begin
    err_d     = err_q;
    err_sel_d = err_sel_q;
    if (err_clr) begin
      err_d     = 1'b0;
      err_sel_d = '0;
    end
    if (in_fire && !sel_ok) begin
      err_d = 1'b1;
      if (!err_q || err_clr) err_sel_d = sel;
    end
  end

  // State, buffer and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      err_q       <= 1'b0;
      err_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      err_q       <= err_d;
      err_sel_q   <= err_sel_d;
    end
  end

`ifdef MUX_DATA_SOURCE_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Saturating output-transfer count; flush takes priority over a fire.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (flush) xfer_cnt_d = '0;
    else if (out_fire && (xfer_cnt_q != 16'hFFFF)) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  // Transfer counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_data_source_pipe.sv
// Bench for mux_data_source_pipe: table-driven cycle vectors plus a
// scoreboard that predicts every output beat from the accepted inputs,
// followed by hand-written out-of-range, flush, stats and reset sequences.
module tb_mux_data_source_pipe;

  localparam int          DATA_W  = 32;
  localparam int          NUM_SRC = 10;
  localparam int          SEL_W   = 4;
  localparam logic [31:0] BASE    = 32'h1000_0000;

  logic                      clk;
  logic                      reset;
  logic [NUM_SRC*DATA_W-1:0] src_in;
  logic [SEL_W-1:0]          sel;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;
  logic                      flush;
  logic                      err;
  logic [SEL_W-1:0]          err_sel;
  logic                      err_clr;
  logic [15:0]               xfer_cnt;

  mux_data_source_pipe #(
    .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEFAULT_VAL(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .src_in(src_in), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .err(err), .err_sel(err_sel), .err_clr(err_clr),
    .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of predicted output beats
  typedef struct {
    logic [31:0]      data;
    logic [SEL_W-1:0] sel;
  } beat_t;
  beat_t sb[$];

  always @(negedge clk) begin
    beat_t e;
    beat_t n;
    if (reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: output %h fired, expected no beat", out_data);
        end else begin
          e = sb.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_sel", 32'(out_sel), 32'(e.sel));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) begin
        n.sel  = sel;
        n.data = (int'(sel) < NUM_SRC) ? src_in[int'(sel)*DATA_W +: DATA_W] : 32'h0;
        sb.push_back(n);
      end
    end
  end

  // Cycle vectors: inputs plus expected in_ready/out_valid/out_data that cycle
  typedef struct {
    logic [3:0]  sel;
    logic        iv;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic        chk;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic iv, input logic ordy,
                       input logic fl, input logic clr);
    sel = s; in_valid = iv; out_ready = ordy; flush = fl; err_clr = clr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NUM_SRC; k++) src_in[k*DATA_W +: DATA_W] = BASE + 32'(k);

    // streaming sel=0..9 then drain; backpressure on sel=2/3
    tbl[0] = '{4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    for (int k = 1; k < 10; k++)
      tbl[k] = '{4'(k), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BASE + 32'(k - 1)};
    tbl[10] = '{4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BASE + 32'd9};
    tbl[11] = '{4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, BASE + 32'd2};
    tbl[14] = '{4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, BASE + 32'd2};
    tbl[15] = '{4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, BASE + 32'd2};
    tbl[16] = '{4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BASE + 32'd3};
    tbl[17] = '{4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

    reset = 1'b1;
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_sel", 32'(err_sel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    step();

    // table-driven streaming and backpressure
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].sel, tbl[i].iv, tbl[i].ordy, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ir));
      check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].chk) check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_data);
      step();
    end

    // out-of-range selects and clear/set collision
    drive(4'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("oor12_err", 32'(err), 32'd1);
    check("oor12_err_sel", 32'(err_sel), 32'd12);
    check("oor12_out_data", out_data, 32'h0);
    drive(4'd14, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("oor14_err_sel_kept", 32'(err_sel), 32'd12);
    check("oor14_out_sel", 32'(out_sel), 32'd14);
    drive(4'd15, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check("clr_set_err", 32'(err), 32'd1);
    check("clr_set_err_sel", 32'(err_sel), 32'd15);
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check("clr_err", 32'(err), 32'd0);
    check("clr_err_sel", 32'(err_sel), 32'd0);
    check("clr_drained", 32'(out_valid), 32'd0);

    // flush while full with a pending input
    drive(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_in_ready_low", 32'(in_ready), 32'd0);
    step();
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    step();
    check("flush_no_accept", 32'(out_valid), 32'd0);

`ifdef MUX_DATA_SOURCE_STATS_EN
    drive(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check("stats_zero", 32'(xfer_cnt), 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(4'(k), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("stats_five", 32'(xfer_cnt), 32'd5);
    drive(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check("stats_flush", 32'(xfer_cnt), 32'd0);
    drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    check("stats_tied_zero", 32'(xfer_cnt), 32'd0);
`endif

    // asynchronous reset while full and erroring
    drive(4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("pre_rst_err", 32'(err), 32'd1);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    sb.delete();
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_err", 32'(err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
